receiver_controller: RTL and testbench
======================================

Name: receiver_controller

Overview:
Sequences the receive packet buffer between the demodulator bit decisions and the UART transmit side. It hunts for the preamble in the demodulated bit stream, then gates exactly FRAME_BITS payload bits into the buffer as read strobes. It waits for the buffer's packet-complete flag, hands the packet to UART with a valid/ready handshake, and then clears the buffer for the next frame. It also aborts stalled frames on a bit-gap timeout.

Parameters:
PREAMBLE_LENGTH, 8, number of preamble bits to match (from the shared parameters header)
PREAMBLE_PATTERN, 8'hD5, preamble value; the newest received bit is the LSB
FRAME_BITS, 40, read strobes issued per frame; equals PACKET_WIDTH_OVERHEAD - PREAMBLE_LENGTH
TIMEOUT_CYCLES, 1024, maximum clk cycles between bit_valid pulses in RECEIVE, or total cycles in WAIT_SEND

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous, active-low reset
bit_valid  input  1  one-cycle pulse: demodulator has decided a bit
bit_data  input  1  decided bit, qualified by bit_valid
buf_read  output  1  registered one-cycle write strobe to the packet buffer
buf_data  output  1  registered copy of bit_data, aligned with buf_read
buf_clear  output  1  registered; held high to empty or hold the buffer
buf_send  input  1  packet-complete flag from the buffer
pkt_valid  output  1  packet available to UART
pkt_ready  input  1  UART accepts the packet
busy  output  1  high in every state except HUNT
rx_error  output  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (async assert, sync release) sets state = HUNT, buf_clear = 1, and all other outputs, counters and the preamble shift register to 0.
- All outputs are registered. buf_read and buf_data appear 1 cycle after the qualifying bit_valid.
- HUNT:
  - buf_clear = 1.
  - On each bit_valid: shreg <= {shreg[PREAMBLE_LENGTH-2:0], bit_data}, and fill count increments, saturating at PREAMBLE_LENGTH.
  - Match occurs when fill == PREAMBLE_LENGTH and the next shreg value == PREAMBLE_PATTERN. On a match, go to RECEIVE with bit_cnt = 0 and timer = 0.
  - The matching preamble bit is not written to the buffer.
- RECEIVE:
  - buf_clear = 0.
  - On each bit_valid: issue buf_read with buf_data = bit_data, bit_cnt++, timer = 0.
  - When bit_valid arrives with bit_cnt == FRAME_BITS-1, go to WAIT_SEND with timer = 0.
  - Without bit_valid, timer++. When timer reaches TIMEOUT_CYCLES-1, go to FLUSH and pulse rx_error.
  - If bit_valid and timeout occur in the same cycle, bit_valid wins and the timer is reset.
- WAIT_SEND:
  - bit_valid is ignored; no strobes are issued.
  - buf_send == 1 goes to HANDOFF.
  - Timer expiry goes to FLUSH and pulses rx_error.
- HANDOFF:
  - pkt_valid = 1, held until a cycle with pkt_valid & pkt_ready. On that handshake, go to FLUSH; pkt_valid drops on the next cycle.
  - No timeout applies here; the UART may stall indefinitely.
  - bit_valid is ignored, and frames arriving meanwhile are dropped.
- FLUSH: one cycle. buf_clear = 1, shreg = 0, fill = 0, then go to HUNT.
- Width rules:
  - bit_cnt is $clog2(FRAME_BITS+1) bits wide.
  - The timer is $clog2(TIMEOUT_CYCLES) bits wide and never wraps: it is cleared on every state entry.
- buf_read is never high while buf_clear is high. buf_read strobes per frame are exactly FRAME_BITS.
- Asserting reset_n low mid-frame returns the block to HUNT within the same cycle. buf_clear = 1 drops any partial frame.

Decomposition:
- Shared parameters header holds PREAMBLE_LENGTH, PREAMBLE_PATTERN, PACKET_WIDTH_OVERHEAD, the derived FRAME_BITS, and TIMEOUT_CYCLES.
- Shared package holds the state enum rx_state_t {HUNT, RECEIVE, WAIT_SEND, HANDOFF, FLUSH}.
- One sub-module, preamble_detector, owns the shift register, fill count and match flag. Its inputs are clk, reset_n, bit_valid, bit_data and flush; its output is match.

Test Plan:
- Reset: hold reset_n low for 3 cycles -> buf_clear=1, buf_read=0, pkt_valid=0, busy=0. Release -> outputs stay in the same state.
- Nominal frame: bits 1,1,0,1,0,1,0,1 then 40 payload bits of 0xA5 pattern, then buf_send pulse, pkt_ready=1 -> exactly 40 buf_read pulses with matching buf_data, each 1 cycle after bit_valid. pkt_valid high for 1 cycle, then buf_clear=1 and return to HUNT.
- False preamble: 7 bits 1010101 then 0 -> no match, no buf_read. Followed by a valid 0xD5 run -> match after its 8th bit.
- Gap timeout: preamble then 10 payload bits, then silence for 1024 cycles -> rx_error pulses once, buf_clear=1 the next cycle, busy drops, and only 10 buf_read pulses were issued.
- UART backpressure: frame completes with pkt_ready=0 for 50 cycles and 20 extra bit_valid pulses -> pkt_valid held for 50 cycles, zero extra buf_read, FLUSH after the ready cycle.
- Mid-frame reset: reset_n low after 20 payload bits -> immediate HUNT, buf_clear=1. A following full frame receives exactly 40 strobes.

Source files
------------

// File: rtl/receiver_controller_pkg.sv
// Shared constants and state encoding for the receive-path controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package receiver_controller_pkg;

    // Preamble framing
    localparam int PREAMBLE_LENGTH = 8;
    localparam logic [PREAMBLE_LENGTH-1:0] PREAMBLE_PATTERN = 8'hD5;

    // Total packet length on air, of which the preamble is the leading part
    localparam int PACKET_WIDTH_OVERHEAD = 48;
    localparam int FRAME_BITS = PACKET_WIDTH_OVERHEAD - PREAMBLE_LENGTH;

    // Bit-gap limit in RECEIVE and total dwell limit in WAIT_SEND
    localparam int TIMEOUT_CYCLES = 1024;

    // Derived widths
    localparam int BIT_CNT_W = $clog2(FRAME_BITS + 1);
    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES);
    localparam int FILL_W = $clog2(PREAMBLE_LENGTH + 1);

    typedef enum logic [2:0] {
        HUNT,
        RECEIVE,
        WAIT_SEND,
        HANDOFF,
        FLUSH
    } rx_state_t;

endpackage

// File: rtl/receiver_controller_if.sv
// Bundles the demodulator, packet-buffer and UART handshake signals.
// Latency: n/a (wiring only).
// Backpressure: pkt_valid/pkt_ready; the bit stream itself has none.
interface receiver_controller_if;
    logic bit_valid;
    logic bit_data;
    logic buf_read;
    logic buf_data;
    logic buf_clear;
    logic buf_send;
    logic pkt_valid;
    logic pkt_ready;
    logic busy;
    logic rx_error;

    // Controller side
    modport master (
        input  bit_valid, bit_data, buf_send, pkt_ready,
        output buf_read, buf_data, buf_clear, pkt_valid, busy, rx_error
    );

    // Environment side (demodulator, buffer, UART)
    modport slave (
        output bit_valid, bit_data, buf_send, pkt_ready,
        input  buf_read, buf_data, buf_clear, pkt_valid, busy, rx_error
    );
endinterface

// File: rtl/receiver_controller_preamble_detector.sv
// Sliding-window preamble matcher over the decided bit stream.
// Latency: match is combinational in the cycle of the completing bit.
// Backpressure: none; every qualified bit is consumed.
module preamble_detector
    import receiver_controller_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic bit_valid,
    input  logic bit_data,
    input  logic flush,
    output logic match
);

    logic [PREAMBLE_LENGTH-1:0] shreg;
    logic [PREAMBLE_LENGTH-1:0] shreg_nxt;
    logic [FILL_W-1:0]          fill;
    logic [FILL_W-1:0]          fill_nxt;

    // Next window and fill; match looks at the window including the current bit
    always_comb begin
        shreg_nxt = {shreg[PREAMBLE_LENGTH-2:0], bit_data};
        fill_nxt  = (fill == FILL_W'(PREAMBLE_LENGTH)) ? fill : fill + 1'b1;
        match     = bit_valid && !flush &&
                    (fill_nxt == FILL_W'(PREAMBLE_LENGTH)) &&
                    (shreg_nxt == PREAMBLE_PATTERN);
    end

    // Window and fill registers; flush restarts the hunt from an empty window
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            fill  <= '0;
        end else if (flush) begin
            shreg <= '0;
            fill  <= '0;
        end else if (bit_valid) begin
            shreg <= shreg_nxt;
            fill  <= fill_nxt;
        end
    end

endmodule

// File: rtl/receiver_controller.sv
// Hunts preamble, strobes FRAME_BITS payload bits into the buffer, hands off to UART.
// Latency: buf_read/buf_data one cycle after bit_valid; all outputs registered.
// Backpressure: pkt_valid held until pkt_ready; bits arriving meanwhile are dropped.
module receiver_controller
    import receiver_controller_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    receiver_controller_if.master rx
);

    rx_state_t            state;
    rx_state_t            state_nxt;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [BIT_CNT_W-1:0] bit_cnt_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    logic                 abort;
    logic                 match;
    logic                 hunt_bit_valid;

    logic buf_read_q, buf_data_q, buf_clear_q, pkt_valid_q, busy_q, rx_error_q;
    logic buf_read_d, buf_data_d, buf_clear_d, pkt_valid_d, busy_d, rx_error_d;

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);
    localparam logic [TIMER_W-1:0]   TIMER_MAX = TIMER_W'(TIMEOUT_CYCLES - 1);

    // The detector only sees bits while hunting so payload never re-triggers it
    assign hunt_bit_valid = rx.bit_valid && (state == HUNT);

    preamble_detector u_preamble_detector (
        .clk       (clk),
        .reset_n   (reset_n),
        .bit_valid (hunt_bit_valid),
        .bit_data  (rx.bit_data),
        .flush     (state == FLUSH),
        .match     (match)
    );

    // State, bit counter and timer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= HUNT;
            bit_cnt <= '0;
            timer   <= '0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            timer   <= timer_nxt;
        end
    end

    // Next-state logic; timer is zeroed on every state entry so it never wraps
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        timer_nxt   = timer;
        abort       = 1'b0;
        case (state)
            HUNT: begin
                if (match) begin
                    state_nxt   = RECEIVE;
                    bit_cnt_nxt = '0;
                    timer_nxt   = '0;
                end
            end
            RECEIVE: begin
                // A bit arriving on the expiry cycle wins over the timeout
                if (rx.bit_valid) begin
                    bit_cnt_nxt = bit_cnt + 1'b1;
                    timer_nxt   = '0;
                    if (bit_cnt == LAST_BIT) begin
                        state_nxt = WAIT_SEND;
                    end
                end else if (timer == TIMER_MAX) begin
                    state_nxt = FLUSH;
                    timer_nxt = '0;
                    abort     = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            WAIT_SEND: begin
                if (rx.buf_send) begin
                    state_nxt = HANDOFF;
                    timer_nxt = '0;
                end else if (timer == TIMER_MAX) begin
                    state_nxt = FLUSH;
                    timer_nxt = '0;
                    abort     = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            HANDOFF: begin
                // UART may stall indefinitely; no timeout here
                if (pkt_valid_q && rx.pkt_ready) begin
                    state_nxt = FLUSH;
                    timer_nxt = '0;
                end
            end
            FLUSH: begin
                state_nxt   = HUNT;
                bit_cnt_nxt = '0;
                timer_nxt   = '0;
            end
            default: begin
                state_nxt   = HUNT;
                bit_cnt_nxt = '0;
                timer_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so registered outputs track state
    always_comb begin
        buf_read_d  = rx.bit_valid && (state == RECEIVE);
        buf_data_d  = buf_read_d ? rx.bit_data : 1'b0;
        buf_clear_d = (state_nxt == HUNT) || (state_nxt == FLUSH);
        pkt_valid_d = (state_nxt == HANDOFF);
        busy_d      = (state_nxt != HUNT);
        rx_error_d  = abort;
    end

    // Output registers; reset leaves the buffer held clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_read_q  <= 1'b0;
            buf_data_q  <= 1'b0;
            buf_clear_q <= 1'b1;
            pkt_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            rx_error_q  <= 1'b0;
        end else begin
            buf_read_q  <= buf_read_d;
            buf_data_q  <= buf_data_d;
            buf_clear_q <= buf_clear_d;
            pkt_valid_q <= pkt_valid_d;
            busy_q      <= busy_d;
            rx_error_q  <= rx_error_d;
        end
    end

    assign rx.buf_read  = buf_read_q;
    assign rx.buf_data  = buf_data_q;
    assign rx.buf_clear = buf_clear_q;
    assign rx.pkt_valid = pkt_valid_q;
    assign rx.busy      = busy_q;
    assign rx.rx_error  = rx_error_q;

endmodule

// File: tb/tb_receiver_controller.sv
// Directed bench for receiver_controller with hand-computed expectations.
// Latency checked: buf_read/buf_data one cycle after bit_valid.
// Backpressure checked: pkt_valid held while pkt_ready is low.
module tb_receiver_controller;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    int   rd_cnt;
    int   err_cnt;
    int   overlap_cnt;
    int   rd_base;
    int   err_base;
    int   held;

    receiver_controller_if rx_if ();

    receiver_controller dut (
        .clk     (clk),
        .reset_n (reset_n),
        .rx      (rx_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobes, error pulses and strobe/clear overlaps away from the edge
    always @(negedge clk) begin
        if (reset_n) begin
            if (rx_if.buf_read === 1'b1) rd_cnt = rd_cnt + 1;
            if (rx_if.rx_error === 1'b1) err_cnt = err_cnt + 1;
            if (rx_if.buf_read === 1'b1 && rx_if.buf_clear === 1'b1) overlap_cnt = overlap_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One bit pulse, check strobe one cycle later, then one idle cycle
    task automatic send_bit(input logic b, input logic exp_rd, input string tag);
        rx_if.bit_valid = 1'b1;
        rx_if.bit_data  = b;
        step();
        rx_if.bit_valid = 1'b0;
        check({tag, "_rd"}, rx_if.buf_read, exp_rd);
        if (exp_rd) check({tag, "_dat"}, rx_if.buf_data, b);
        step();
    endtask

    task automatic send_preamble();
        logic [7:0] p;
        p = 8'hD5;
        for (int i = 0; i < 8; i++) send_bit(p[7-i], 1'b0, "pre");
    endtask

    task automatic send_payload(input int n);
        logic [7:0] a5;
        a5 = 8'hA5;
        for (int i = 0; i < n; i++) send_bit(a5[7-(i%8)], 1'b1, "pay");
    endtask

    initial begin
        logic [7:0] fp;
        n_checks = 0; n_fail = 0;
        rd_cnt = 0; err_cnt = 0; overlap_cnt = 0;
        rx_if.bit_valid = 1'b0;
        rx_if.bit_data  = 1'b0;
        rx_if.buf_send  = 1'b0;
        rx_if.pkt_ready = 1'b0;

        // Reset held for three cycles
        reset_n = 1'b0;
        repeat (3) step();
        check("rst_clear", rx_if.buf_clear, 1'b1);
        check("rst_read", rx_if.buf_read, 1'b0);
        check("rst_pvld", rx_if.pkt_valid, 1'b0);
        check("rst_busy", rx_if.busy, 1'b0);
        check("rst_err", rx_if.rx_error, 1'b0);
        reset_n = 1'b1;
        repeat (2) step();
        check("rel_clear", rx_if.buf_clear, 1'b1);
        check("rel_busy", rx_if.busy, 1'b0);
        check("rel_pvld", rx_if.pkt_valid, 1'b0);

        // Nominal frame
        rd_base = rd_cnt;
        send_preamble();
        check("nom_busy", rx_if.busy, 1'b1);
        check("nom_clear", rx_if.buf_clear, 1'b0);
        send_payload(40);
        check("nom_ws_busy", rx_if.busy, 1'b1);
        check("nom_ws_pvld", rx_if.pkt_valid, 1'b0);
        send_bit(1'b1, 1'b0, "ws_ignored");
        rx_if.pkt_ready = 1'b1;
        rx_if.buf_send  = 1'b1;
        step();
        rx_if.buf_send  = 1'b0;
        check("nom_pvld_hi", rx_if.pkt_valid, 1'b1);
        step();
        check("nom_pvld_lo", rx_if.pkt_valid, 1'b0);
        check("nom_flush_clear", rx_if.buf_clear, 1'b1);
        check("nom_flush_busy", rx_if.busy, 1'b1);
        step();
        check("nom_hunt_busy", rx_if.busy, 1'b0);
        check("nom_hunt_clear", rx_if.buf_clear, 1'b1);
        check("nom_strobes", rd_cnt - rd_base, 40);
        rx_if.pkt_ready = 1'b0;

        // False preamble 1010101 then 0, then a valid D5 run
        rd_base = rd_cnt;
        fp = 8'hAA;
        for (int i = 0; i < 8; i++) send_bit(fp[7-i], 1'b0, "false");
        check("false_busy", rx_if.busy, 1'b0);
        fp = 8'hD5;
        for (int i = 0; i < 7; i++) send_bit(fp[7-i], 1'b0, "pre2");
        check("pre2_7_busy", rx_if.busy, 1'b0);
        send_bit(fp[0], 1'b0, "pre2_8");
        check("pre2_8_busy", rx_if.busy, 1'b1);
        check("false_no_strobe", rd_cnt - rd_base, 0);

        // Gap timeout after 10 payload bits
        err_base = err_cnt;
        send_payload(10);
        repeat (1022) step();
        check("to_early_err", rx_if.rx_error, 1'b0);
        check("to_early_busy", rx_if.busy, 1'b1);
        step();
        check("to_err", rx_if.rx_error, 1'b1);
        check("to_clear", rx_if.buf_clear, 1'b1);
        step();
        check("to_err_pulse", rx_if.rx_error, 1'b0);
        check("to_busy", rx_if.busy, 1'b0);
        check("to_clear2", rx_if.buf_clear, 1'b1);
        check("to_err_cnt", err_cnt - err_base, 1);
        check("to_strobes", rd_cnt - rd_base, 10);

        // UART backpressure with bits arriving during handoff
        rd_base = rd_cnt;
        send_preamble();
        send_payload(40);
        rx_if.buf_send = 1'b1;
        step();
        rx_if.buf_send = 1'b0;
        held = 0;
        for (int i = 0; i < 50; i++) begin
            if (rx_if.pkt_valid === 1'b1) held++;
            rx_if.bit_valid = (i < 40) && (i % 2 == 0);
            rx_if.bit_data  = 1'b1;
            step();
        end
        rx_if.bit_valid = 1'b0;
        check("bp_held", held, 50);
        check("bp_pvld_still", rx_if.pkt_valid, 1'b1);
        rx_if.pkt_ready = 1'b1;
        step();
        rx_if.pkt_ready = 1'b0;
        check("bp_pvld_lo", rx_if.pkt_valid, 1'b0);
        check("bp_flush_clear", rx_if.buf_clear, 1'b1);
        step();
        check("bp_hunt_busy", rx_if.busy, 1'b0);
        check("bp_strobes", rd_cnt - rd_base, 40);

        // Mid-frame reset then a full frame
        send_preamble();
        send_payload(20);
        reset_n = 1'b0;
        #2;
        check("mr_clear", rx_if.buf_clear, 1'b1);
        check("mr_busy", rx_if.busy, 1'b0);
        check("mr_read", rx_if.buf_read, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        rd_base = rd_cnt;
        send_preamble();
        send_payload(40);
        check("mr_strobes", rd_cnt - rd_base, 40);
        rx_if.pkt_ready = 1'b1;
        rx_if.buf_send  = 1'b1;
        step();
        rx_if.buf_send  = 1'b0;
        check("mr_pvld", rx_if.pkt_valid, 1'b1);
        repeat (2) step();
        check("mr_end_busy", rx_if.busy, 1'b0);
        rx_if.pkt_ready = 1'b0;

        check("no_overlap", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
